// File: rtl/alu_mdu_sequencer.sv
// EX-stage ALU decode plus RV32M sequencing: Operation is combinational, M-ops stall for lat+1 cycles.
// Optional divide support is enabled by defining ALU_MDU_DIV_EN; otherwise divides raise illegal.
module alu_mdu_sequencer #(
  parameter int OP_W       = 4,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  logic            is_rtype,
  input  logic            flush,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  output logic [OP_W-1:0] Operation,
  output logic            md_start,
  output logic [2:0]      md_op,
  output logic            stall,
  output logic            md_done,
  output logic            illegal
);

  localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
`ifdef ALU_MDU_DIV_EN
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);
`endif

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1011;
  localparam logic [3:0] OP_BLT  = 4'b1100;
  localparam logic [3:0] OP_BGE  = 4'b1101;
  localparam logic [3:0] OP_BLTU = 4'b1110;
  localparam logic [3:0] OP_BGEU = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       md_op_q, md_op_d;

  logic       m_op;
  logic       is_div;
  logic       start_ok;
  logic       div_bad;
  logic [3:0] op_sel;

  // ALU operation decode
  always_comb begin
    op_sel = OP_ADD;
    case (ALUOp)
      2'b01: begin
        case (Funct3)
          3'b000:  op_sel = OP_BEQ;
          3'b001:  op_sel = OP_BNE;
          3'b100:  op_sel = OP_BLT;
          3'b101:  op_sel = OP_BGE;
          3'b110:  op_sel = OP_BLTU;
          3'b111:  op_sel = OP_BGEU;
          default: op_sel = OP_ADD;
        endcase
      end
      2'b10: begin
        // M-extension encodings are not ALU operations; the MDU produces the result
        if (!(is_rtype && Funct7 == 7'b0000001)) begin
          case (Funct3)
            3'b000:  op_sel = (is_rtype && Funct7 == 7'b0100000) ? OP_SUB : OP_ADD;
            3'b001:  op_sel = OP_SLL;
            3'b010:  op_sel = OP_SLT;
            3'b011:  op_sel = OP_SLTU;
            3'b100:  op_sel = OP_XOR;
            3'b101:  op_sel = Funct7[5] ? OP_SRA : OP_SRL;
            3'b110:  op_sel = OP_OR;
            default: op_sel = OP_AND;
          endcase
        end
      end
      default: op_sel = OP_ADD;
    endcase
  end

  assign Operation = OP_W'(op_sel);

  assign m_op   = valid && (ALUOp == 2'b10) && is_rtype && (Funct7 == 7'b0000001);
  assign is_div = Funct3[2];

`ifdef ALU_MDU_DIV_EN
  assign start_ok = m_op;
  assign div_bad  = 1'b0;
`else
  assign start_ok = m_op && !is_div;
  assign div_bad  = m_op && is_div;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_op_d = md_op_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok && !flush) begin
          state_d = S_BUSY;
          md_op_d = Funct3;
`ifdef ALU_MDU_DIV_EN
          cnt_d   = is_div ? DIV_LAST : MUL_LAST;
`else
          cnt_d   = MUL_LAST;
`endif
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      md_op_q <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_op_q <= md_op_d;
    end
  end

  // Start/stall must be visible in the issue cycle, so they decode the live inputs
  assign md_start = !reset && (state_q == S_IDLE) && start_ok && !flush;
  assign illegal  = !reset && (state_q == S_IDLE) && div_bad && !flush;
  assign stall    = !reset && (md_start || (state_q == S_BUSY));
  assign md_done  = !reset && (state_q == S_DONE) && !flush;
  assign md_op    = md_op_q;

endmodule
